// File: rtl/lsu_ctrl.sv
// Load/store unit controller: execute-stage ops to a req/ack data memory.
// Handles byte-lane steering, load extension, misalign/illegal and timeout.
module lsu_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              op_wr,
  input  logic [2:0]        op_funct3,
  input  logic [XLEN-1:0]   op_addr,
  input  logic [XLEN-1:0]   op_wdata,
  input  logic [4:0]        op_rd,
  input  logic              kill,
  output logic              stall,
  output logic              ld_valid,
  output logic [XLEN-1:0]   ld_data,
  output logic [4:0]        ld_rd,
  output logic              st_done,
  output logic              misalign,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TLAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nx;
  logic [1:0]      sz;
  logic [3:0]      nbytes;
  logic [OB-1:0]   off, off_r;
  logic            illegal, misal;
  logic            accept, ack, tmo;
  logic [NB-1:0]   be_nx;
  logic [XLEN-1:0] wd_nx;
  logic [2:0]      f3_r;
  logic [4:0]      rd_r;
  logic            killed;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] sh, ld_nx;
  logic [6:0]      lw;
  logic            top, sgn;

  assign op_ready = (state == IDLE) & ~kill;
  assign stall    = (state == BUSY);
  assign accept   = op_valid & op_ready;
  assign ack      = mem_req & mem_ack;
  assign tmo      = (TIMEOUT > 0) & (state == BUSY)
                  & ~mem_ack & (cnt == TLAST);

  assign sz     = op_funct3[1:0];
  assign nbytes = 4'd1 << sz;
  assign off    = op_addr[OB-1:0];
  assign misal  = |(off & OB'(nbytes - 4'd1));

  always_comb begin
    illegal = (op_funct3 == 3'b111) | (op_wr & op_funct3[2]);
    if (XLEN == 32)
      illegal = illegal | (sz == 2'b11) | (op_funct3 == 3'b110);
  end

  // Store bytes replicate across lanes; nbytes is a power of two.
  always_comb begin
    be_nx = '0;
    wd_nx = '0;
    for (int i = 0; i < NB; i++) begin
      be_nx[i] = (i >= int'(off)) && (i < int'(off) + int'(nbytes));
      wd_nx[8*i +: 8] = op_wdata[8*(i & (int'(nbytes) - 1)) +: 8];
    end
  end

  assign sh  = mem_rdata >> {off_r, 3'b000};
  assign lw  = 7'd8 << f3_r[1:0];
  assign sgn = ~f3_r[2];

  always_comb begin
    unique case (f3_r[1:0])
      2'd0:    top = sh[7];
      2'd1:    top = sh[15];
      default: top = sh[31];
    endcase
  end

  always_comb begin
    ld_nx = '0;
    for (int i = 0; i < XLEN; i++)
      ld_nx[i] = (i < int'(lw)) ? sh[i] : (sgn & top);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept & ~(illegal | misal)) state_nx = BUSY;
      BUSY: if (ack | tmo) state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_valid  <= 1'b0;
      ld_data   <= '0;
      ld_rd     <= '0;
      st_done   <= 1'b0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      f3_r      <= '0;
      rd_r      <= '0;
      off_r     <= '0;
      killed    <= 1'b0;
      cnt       <= '0;
    end else begin
      ld_valid <= 1'b0;
      st_done  <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          if (illegal | misal) begin
            misalign <= 1'b1;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= op_wr;
            mem_addr  <= {op_addr[XLEN-1:OB], {OB{1'b0}}};
            mem_be    <= be_nx;
            mem_wdata <= wd_nx;
            f3_r      <= op_funct3;
            rd_r      <= op_rd;
            off_r     <= off;
            killed    <= 1'b0;
            cnt       <= '0;
          end
        end
      end else begin
        if (kill & ~mem_we) killed <= 1'b1;
        if (ack) begin
          mem_req <= 1'b0;
          if (mem_we) begin
            st_done <= 1'b1;
          end else if (!(killed | kill)) begin
            ld_valid <= 1'b1;
            ld_data  <= ld_nx;
            ld_rd    <= rd_r;
          end
        end else if (tmo) begin
          mem_req <= 1'b0;
          bus_err <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Parametrised load/store unit controller sitting between the processor's execute stage and a variable-latency data memory. It replaces the fixed single-cycle data-cache path (whose stall is tied low) with a req/ack memory handshake, generates the pipeline stall, and adds byte-lane steering, sign/zero extension, misalignment detection, a kill input for squashed ops, and an optional bus timeout.

## Interface
Parameters:
- XLEN, 32, data/address width; legal values 32 or 64. NB = XLEN/8 byte lanes, OB = log2(NB).
- TIMEOUT, 0, max BUSY cycles awaiting mem_ack; 0 disables the timeout.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- op_valid  in  1  execute stage presents a memory op.
- op_ready  out  1  op accepted at this edge; equals (state==IDLE) & ~kill.
- op_wr  in  1  1 = store, 0 = load.
- op_funct3  in  3  RISC-V width/sign code (LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD).
- op_addr  in  XLEN  byte address (ALU output).
- op_wdata  in  XLEN  store data (rs2).
- op_rd  in  5  load destination register.
- kill  in  1  squash (jump taken); blocks acceptance, suppresses in-flight load result.
- stall  out  1  hold the pipeline; high whenever state==BUSY.
- ld_valid  out  1  one-cycle pulse, load result valid.
- ld_data  out  XLEN  extended load result.
- ld_rd  out  5  destination of ld_valid.
- st_done  out  1  one-cycle pulse, store committed.
- misalign  out  1  one-cycle pulse, accepted op misaligned or illegal funct3.
- bus_err  out  1  one-cycle pulse, timeout expired.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  write enable.
- mem_addr  out  XLEN  op_addr with low OB bits zeroed.
- mem_be  out  NB  byte enables.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_ack  in  1  memory completion; sampled only while mem_req=1.
- mem_rdata  in  XLEN  read data, valid with mem_ack.

## Operation
- FSM states IDLE, BUSY. Reset → IDLE; all outputs 0, op_ready=1 (kill low).
- IDLE: on op_valid & op_ready, decode size (1/2/4/8 bytes). Illegal = funct3 LD/SD/LWU when XLEN=32, or 111/other unused codes. Misaligned = addr not multiple of size. Either → misalign pulse next cycle, no memory access, stay IDLE. Otherwise register addr, mem_we, mem_be, mem_wdata, funct3, op_rd; → BUSY.
- mem_be = ((1<<size)-1) << addr[OB-1:0]. mem_wdata = low size bytes of op_wdata replicated across all lanes.
- BUSY: mem_req=1. On mem_ack: load → next cycle ld_valid=1, ld_data = (mem_rdata >> 8*offset) truncated to size, sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU; LD unchanged); store → st_done pulse next cycle; → IDLE.
- kill in IDLE: op_ready=0, op not accepted. kill during BUSY on a load: set killed flag; memory transaction completes, ld_valid suppressed. kill during BUSY on a store: ignored, store completes (already committed).
- Timeout (TIMEOUT>0): counter clears on entry to BUSY, increments each BUSY cycle without ack; when it reaches TIMEOUT → bus_err pulse, mem_req drops, → IDLE, no ld_valid/st_done. mem_ack while mem_req=0 ignored.
- Ack and timeout in same cycle: ack wins.
- Async reset mid-BUSY: immediate return to IDLE, mem_req=0, pending result discarded.

## Timing
- Accept at edge N; mem_req high cycle N+1; ack sampled at edge M≥N+1; ld_valid/st_done high cycle M+1 only. Minimum accept-to-result: 2 cycles.
- stall high from cycle N+1 through cycle of ack; low in result cycle, so next op can be accepted on the edge ending the result cycle.
- misalign high exactly cycle N+1; bus_err high exactly cycle after the TIMEOUT-th unacked BUSY cycle.
- All outputs registered except op_ready and stall (decoded from state/kill).
- One op outstanding max; back-to-back ops spaced ≥2 cycles.

## Test plan
- XLEN=32, LB addr 0x103, mem_rdata 0x80FF_FF00 acked 1st cycle → ld_valid cycle N+2, mem_addr 0x100, mem_be 4'b1000, ld_data 0xFFFF_FF80.
- SH addr 0x102, wdata 0x1234_ABCD, ack after 3 cycles → mem_be 4'b1100, mem_wdata 0xABCD_ABCD, stall 3 cycles, st_done one pulse.
- LW addr 0x101 → misalign pulse next cycle, mem_req never asserted; LD with XLEN=32 → misalign; XLEN=64 LD addr 0x8 → legal, mem_be 8'hFF.
- LHU in BUSY, kill pulsed, ack arrives → no ld_valid, FSM IDLE, next LW accepted and returns normally.
- TIMEOUT=4, no ack → bus_err after 4 BUSY cycles, mem_req low; late mem_ack ignored; ack on 4th cycle → ld_valid, no bus_err.
- rst low mid-BUSY → mem_req/stall 0 immediately, no result pulses after release.
